// File: rtl/gf_stream_pkg.sv
// Shared types and constants for the gigafitter word-stream blocks.
package gf_stream_pkg;

  localparam int GF_WORD_W = 48;
  localparam int GF_SEL_W  = 3;
  localparam logic [GF_SEL_W-1:0] GF_SEL_BCAST = 3'b111;

  typedef logic [GF_WORD_W-1:0] gf_word_t;
  typedef logic [GF_SEL_W-1:0]  gf_sel_t;

  function automatic logic gf_sel_is_lane(input gf_sel_t sel, input int n_out);
    return (int'(sel) < n_out);
  endfunction

endpackage

// File: rtl/gf_stream_slot.sv
// One-entry registered slot with valid/ready output; free means a load
// this cycle cannot overwrite an unconsumed word.
module gf_stream_slot
  import gf_stream_pkg::*;
#(
  parameter int DATA_W = GF_WORD_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              free
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign free      = ~valid_q | out_ready;
  assign out_data  = data_q;
  assign out_valid = valid_q;

  // A load wins over a drain so the lane sustains one word per cycle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/demux48_6out_stream.sv
// 1-to-N_OUT word distributor with per-lane register slots and a drop counter.
// Define GF_DEMUX_BROADCAST_EN to make select 7 load every lane at once.
module demux48_6out_stream
  import gf_stream_pkg::*;
#(
  parameter int DATA_W = GF_WORD_W,
  parameter int N_OUT  = 6,
  parameter int CNT_W  = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [GF_SEL_W-1:0]       in_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [N_OUT*DATA_W-1:0]   out_data,
  output logic [N_OUT-1:0]          out_valid,
  input  logic [N_OUT-1:0]          out_ready,
  output logic [CNT_W-1:0]          drop_count
);

  logic [N_OUT-1:0] lane_free;
  logic [N_OUT-1:0] lane_hit;
  logic [N_OUT-1:0] lane_load;
  logic             sel_legal;
  logic             sel_bcast;
  logic             accept;
  logic             drop;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;

  assign sel_legal = gf_sel_is_lane(in_sel, N_OUT);

`ifdef GF_DEMUX_BROADCAST_EN
  assign sel_bcast = (in_sel == GF_SEL_BCAST);
`else
  assign sel_bcast = 1'b0;
`endif

  // Illegal selects are always ready so a bad word cannot stall the source.
  always_comb begin
    lane_hit  = '0;
    lane_load = '0;
    for (int i = 0; i < N_OUT; i++) begin
      lane_hit[i] = (in_sel == GF_SEL_W'(i));
    end
    if (sel_legal) begin
      in_ready = |(lane_hit & lane_free);
    end else if (sel_bcast) begin
      in_ready = &lane_free;
    end else begin
      in_ready = 1'b1;
    end
    accept = in_valid & in_ready;
    for (int i = 0; i < N_OUT; i++) begin
      lane_load[i] = accept & ((sel_legal & lane_hit[i]) | sel_bcast);
    end
    drop = accept & ~sel_legal & ~sel_bcast;
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_lane
    gf_stream_slot #(.DATA_W(DATA_W)) u_slot (
      .clock     (clock),
      .reset     (reset),
      .load      (lane_load[g]),
      .load_data (in_data),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g*DATA_W +: DATA_W]),
      .out_valid (out_valid[g]),
      .free      (lane_free[g])
    );
  end

  // Saturating drop counter.
  always_comb begin
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != {CNT_W{1'b1}})) begin
      drop_count_d = drop_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      drop_count_d = drop_count_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      drop_count_q <= '0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_demux48_6out_stream.sv
// Self-checking bench for demux48_6out_stream: directed table, corner sequences,
// and randomized traffic checked against a lane-array reference model.
module tb_demux48_6out_stream;

  localparam int DW = 48;
  localparam int NO = 6;
  localparam int CW = 16;
`ifdef GF_DEMUX_BROADCAST_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic [DW-1:0]     in_data;
  logic [2:0]        in_sel;
  logic              in_valid;
  logic              in_ready;
  logic [NO*DW-1:0]  out_data;
  logic [NO-1:0]     out_valid;
  logic [NO-1:0]     out_ready;
  logic [CW-1:0]     drop_count;

  always #5 clock = ~clock;

  demux48_6out_stream #(.DATA_W(DW), .N_OUT(NO), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .drop_count(drop_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what each lane holds, whether it is occupied, drops so far.
  logic [DW-1:0] m_data [NO];
  logic [NO-1:0] m_valid;
  int            m_drops;

  function automatic logic m_ready(input logic [2:0] sel, input logic [NO-1:0] ordy);
    logic [NO-1:0] fr;
    fr = ~m_valid | ordy;
    if (int'(sel) < NO) return fr[sel];
    if (sel == 3'd7 && BCAST) return &fr;
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] sel, input logic [DW-1:0] d,
                       input logic [NO-1:0] ordy);
    in_valid  = v;
    in_sel    = sel;
    in_data   = d;
    out_ready = ordy;
    #1;
  endtask

  task automatic check_model();
    chk("in_ready", 64'(in_ready), 64'(m_ready(in_sel, out_ready)));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    for (int i = 0; i < NO; i++) begin
      chk($sformatf("lane%0d_data", i), 64'(out_data[i*DW +: DW]), 64'(m_data[i]));
    end
    chk("drop_count", 64'(drop_count), 64'(m_drops));
  endtask

  // Advance one clock and apply the handshake rules to the model.
  task automatic step();
    logic acc;
    acc = in_valid & m_ready(in_sel, out_ready);
    @(posedge clock);
    if (reset) begin
      m_valid = '0;
      m_drops = 0;
      for (int i = 0; i < NO; i++) m_data[i] = '0;
    end else begin
      for (int i = 0; i < NO; i++) if (m_valid[i] && out_ready[i]) m_valid[i] = 1'b0;
      if (acc) begin
        if (int'(in_sel) < NO) begin
          m_valid[in_sel] = 1'b1;
          m_data[in_sel]  = in_data;
        end else if (in_sel == 3'd7 && BCAST) begin
          m_valid = '1;
          for (int i = 0; i < NO; i++) m_data[i] = in_data;
        end else if (m_drops < 65535) begin
          m_drops++;
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic cycle(input logic v, input logic [2:0] sel, input logic [DW-1:0] d,
                       input logic [NO-1:0] ordy);
    drive(v, sel, d, ordy);
    check_model();
    step();
  endtask

  typedef struct {
    logic          v;
    logic [2:0]    sel;
    logic [DW-1:0] data;
    logic [NO-1:0] ordy;
    logic          exp_rdy;
    logic [NO-1:0] exp_ov;
    logic [DW-1:0] exp_l2;
    logic [CW-1:0] exp_dc;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic          pend;
    logic          rv;
    logic [2:0]    rs;
    logic [63:0]   rd;

    tbl[0] = '{1'b1, 3'd2, 48'h123456789ABC, 6'b000000, 1'b1, 6'b000000, 48'h0,            16'd0};
    tbl[1] = '{1'b1, 3'd2, 48'hFEDCBA987654, 6'b000000, 1'b0, 6'b000100, 48'h123456789ABC, 16'd0};
    tbl[2] = '{1'b1, 3'd2, 48'hFEDCBA987654, 6'b000100, 1'b1, 6'b000100, 48'h123456789ABC, 16'd0};
    tbl[3] = '{1'b0, 3'd0, 48'h0,            6'b000000, 1'b1, 6'b000100, 48'hFEDCBA987654, 16'd0};
    tbl[4] = '{1'b1, 3'd6, 48'h00000000DEAD, 6'b000000, 1'b1, 6'b000100, 48'hFEDCBA987654, 16'd0};
    tbl[5] = '{1'b1, 3'd6, 48'h00000000DEAD, 6'b000000, 1'b1, 6'b000100, 48'hFEDCBA987654, 16'd1};
    tbl[6] = '{1'b1, 3'd6, 48'h00000000DEAD, 6'b000000, 1'b1, 6'b000100, 48'hFEDCBA987654, 16'd2};
    tbl[7] = '{1'b0, 3'd0, 48'h0,            6'b000000, 1'b1, 6'b000100, 48'hFEDCBA987654, 16'd3};

    m_valid = '0;
    m_drops = 0;
    for (int i = 0; i < NO; i++) m_data[i] = '0;
    reset = 1'b1;
    drive(1'b0, 3'd0, '0, '0);
    @(negedge clock);
    step();
    step();
    reset = 1'b0;

    // Reset state
    drive(1'b0, 3'd0, '0, '0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(|out_data), 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);

    // Directed table: single load, back-pressure, same-cycle drain+load, drops
    for (int k = 0; k < 8; k++) begin
      drive(tbl[k].v, tbl[k].sel, tbl[k].data, tbl[k].ordy);
      chk($sformatf("tbl%0d_in_ready", k), 64'(in_ready), 64'(tbl[k].exp_rdy));
      chk($sformatf("tbl%0d_out_valid", k), 64'(out_valid), 64'(tbl[k].exp_ov));
      chk($sformatf("tbl%0d_lane2", k), 64'(out_data[2*DW +: DW]), 64'(tbl[k].exp_l2));
      chk($sformatf("tbl%0d_drop_count", k), 64'(drop_count), 64'(tbl[k].exp_dc));
      check_model();
      step();
    end

    // Lane 2 streams at one word per cycle
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 3'd2, 48'h100 + 48'(k), 6'b000100);
      chk("burst_in_ready", 64'(in_ready), 64'd1);
      if (k > 0) chk("burst_lane2", 64'(out_data[2*DW +: DW]), 64'h100 + 64'(k - 1));
      check_model();
      step();
    end
    drive(1'b0, 3'd0, '0, 6'b000100);
    chk("burst_last_lane2", 64'(out_data[2*DW +: DW]), 64'h109);
    chk("burst_last_valid", 64'(out_valid), 64'b000100);
    check_model();
    step();

    // Select 7: broadcast or drop depending on build
    cycle(1'b0, 3'd0, '0, '1);
`ifdef GF_DEMUX_BROADCAST_EN
    drive(1'b1, 3'd7, 48'hAAAAAAAAAAAA, 6'b000000);
    chk("bcast_in_ready", 64'(in_ready), 64'd1);
    check_model();
    step();
    drive(1'b1, 3'd7, 48'h555555555555, 6'b101111);
    chk("bcast_valid_all", 64'(out_valid), 64'b111111);
    for (int i = 0; i < NO; i++)
      chk("bcast_lane_data", 64'(out_data[i*DW +: DW]), 64'hAAAAAAAAAAAA);
    chk("bcast_blocked_ready", 64'(in_ready), 64'd0);
    check_model();
    step();
    drive(1'b1, 3'd7, 48'h555555555555, 6'b111111);
    chk("bcast_partial_valid", 64'(out_valid), 64'b010000);
    chk("bcast_partial_lane0", 64'(out_data[0 +: DW]), 64'hAAAAAAAAAAAA);
    check_model();
    step();
    drive(1'b0, 3'd0, '0, 6'b000000);
    chk("bcast2_valid", 64'(out_valid), 64'b111111);
    chk("bcast2_lane5", 64'(out_data[5*DW +: DW]), 64'h555555555555);
    check_model();
    step();
`else
    drive(1'b1, 3'd7, 48'hAAAAAAAAAAAA, 6'b000000);
    chk("sel7_in_ready", 64'(in_ready), 64'd1);
    check_model();
    step();
    drive(1'b0, 3'd0, '0, 6'b000000);
    chk("sel7_no_lane", 64'(out_valid), 64'd0);
    chk("sel7_dropped", 64'(drop_count), 64'd4);
    check_model();
    step();
`endif

    // All lanes full, then reset
    cycle(1'b0, 3'd0, '0, '1);
    for (int i = 0; i < NO; i++) cycle(1'b1, 3'(i), 48'hC0DE00 + 48'(i), '0);
    drive(1'b0, 3'd0, '0, '0);
    chk("full_valid", 64'(out_valid), 64'b111111);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b0, 3'd3, '0, '0);
    chk("rst2_out_valid", 64'(out_valid), 64'd0);
    chk("rst2_out_data", 64'(|out_data), 64'd0);
    chk("rst2_drop_count", 64'(drop_count), 64'd0);
    chk("rst2_in_ready", 64'(in_ready), 64'd1);
    step();
    cycle(1'b1, 3'd3, 48'h33, '0);
    drive(1'b0, 3'd3, '0, '0);
    chk("ready_no_valid_dep", 64'(in_ready), 64'd0);
    step();

    // Randomized traffic; the source holds its word until accepted
    cycle(1'b0, 3'd0, '0, '1);
    pend = 1'b0;
    rv = 1'b0; rs = 3'd0; rd = '0;
    for (int k = 0; k < 3000; k++) begin
      if (!pend) begin
        rv = ($urandom_range(0, 3) != 0);
        rs = 3'($urandom_range(0, 7));
        rd = {$urandom(), $urandom()};
      end
      drive(rv, rs, rd[DW-1:0], NO'($urandom()));
      check_model();
      pend = rv && !m_ready(rs, out_ready);
      step();
    end

    // Drop counter saturation
    reset = 1'b1;
    cycle(1'b0, 3'd0, '0, '0);
    reset = 1'b0;
    drive(1'b1, 3'd6, '0, '0);
    repeat (65534) @(posedge clock);
    m_drops = 65534;
    @(negedge clock);
    chk("sat_fffe", 64'(drop_count), 64'hFFFE);
    for (int k = 0; k < 3; k++) cycle(1'b1, 3'd6, '0, '0);
    drive(1'b0, 3'd0, '0, '0);
    chk("sat_ffff", 64'(drop_count), 64'hFFFF);
    chk("sat_no_lane", 64'(out_valid), 64'd0);
    check_model();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
